// File: rtl/atan_lut.sv
// rtl/atan_lut.sv - arctangent lookup table for the iterative CORDIC rotator
//
// Returns atan(2^-index) in radians as signed Q2.16 (LSB = 2^-16 rad).
// Ports:
//   clock          rising-edge clock for the registered outputs
//   reset_n        asynchronous active-low reset of the registered outputs
//   index          iteration number, unsigned 0..31
//   return_angle   combinational table entry for index (same cycle)
//   return_angle_q return_angle registered one cycle later
//   last_q         registered flag, set when the registered entry is 1 LSB

module atan_lut (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [4:0]  index,
    output logic [17:0] return_angle,
    output logic [17:0] return_angle_q,
    output logic        last_q
);

    // Round-to-nearest of atan(2^-i) * 65536. Beyond index 16 the angle is
    // below half an LSB, so those entries are 0; this also keeps them from
    // ever matching the terminal value of 1.
    always_comb begin
        return_angle = 18'd0;
        case (index)
            5'd0:    return_angle = 18'd51472;
            5'd1:    return_angle = 18'd30386;
            5'd2:    return_angle = 18'd16055;
            5'd3:    return_angle = 18'd8150;
            5'd4:    return_angle = 18'd4091;
            5'd5:    return_angle = 18'd2047;
            5'd6:    return_angle = 18'd1024;
            5'd7:    return_angle = 18'd512;
            5'd8:    return_angle = 18'd256;
            5'd9:    return_angle = 18'd128;
            5'd10:   return_angle = 18'd64;
            5'd11:   return_angle = 18'd32;
            5'd12:   return_angle = 18'd16;
            5'd13:   return_angle = 18'd8;
            5'd14:   return_angle = 18'd4;
            5'd15:   return_angle = 18'd2;
            5'd16:   return_angle = 18'd1;
            default: return_angle = 18'd0;
        endcase
    end

    // Registered copy for pipelined consumers; last_q marks the final
    // useful iteration (entry of exactly 1 LSB).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            return_angle_q <= 18'd0;
            last_q         <= 1'b0;
        end else begin
            return_angle_q <= return_angle;
            last_q         <= (return_angle == 18'd1);
        end
    end

endmodule

// File: tb/tb_atan_lut.sv
// tb/tb_atan_lut.sv - self-checking bench for atan_lut

module tb_atan_lut;

    logic        clock;
    logic        reset_n;
    logic [4:0]  index;
    logic [17:0] return_angle;
    logic [17:0] return_angle_q;
    logic        last_q;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  idx;
        logic [17:0] exp;
    } vec_t;

    vec_t vecs[32];

    atan_lut dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .index          (index),
        .return_angle   (return_angle),
        .return_angle_q (return_angle_q),
        .last_q         (last_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: angle from real arithmetic, rounded to nearest LSB.
    function automatic logic [17:0] ref_angle(input int i);
        real a;
        if (i > 16) return 18'd0;
        a = $atan(1.0 / (2.0 ** i)) * 65536.0;
        return 18'($rtoi(a + 0.5));
    endfunction

    initial begin
        logic [17:0] prev_angle;
        logic [4:0]  prev_idx;
        logic [4:0]  cur;

        for (int i = 0; i < 32; i++) begin
            vecs[i].idx = 5'(i);
            vecs[i].exp = 18'd0;
        end
        vecs[0].exp  = 18'd51472; vecs[1].exp  = 18'd30386;
        vecs[2].exp  = 18'd16055; vecs[3].exp  = 18'd8150;
        vecs[4].exp  = 18'd4091;  vecs[5].exp  = 18'd2047;
        vecs[6].exp  = 18'd1024;  vecs[7].exp  = 18'd512;
        vecs[8].exp  = 18'd256;   vecs[9].exp  = 18'd128;
        vecs[10].exp = 18'd64;    vecs[11].exp = 18'd32;
        vecs[12].exp = 18'd16;    vecs[13].exp = 18'd8;
        vecs[14].exp = 18'd4;     vecs[15].exp = 18'd2;
        vecs[16].exp = 18'd1;

        // Reset held while clock runs
        reset_n = 1'b0;
        index   = 5'd0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_q", 32'(return_angle_q), 32'd0);
        check("reset_last", 32'(last_q), 32'd0);
        check("reset_comb", 32'(return_angle), 32'd51472);

        // Combinational sweep against the table, still in reset
        for (int i = 0; i < 32; i++) begin
            index = vecs[i].idx;
            #1;
            check($sformatf("sweep_%0d", i), 32'(return_angle), 32'(vecs[i].exp));
            check($sformatf("model_%0d", i), 32'(return_angle), 32'(ref_angle(i)));
            check($sformatf("sweep_q_%0d", i), 32'(return_angle_q), 32'd0);
        end

        // Accuracy: within half an LSB of the true angle
        for (int i = 0; i <= 16; i++) begin
            real err;
            index = 5'(i);
            #1;
            err = real'(return_angle) / 65536.0 - $atan(1.0 / (2.0 ** i));
            if (err < 0.0) err = -err;
            check($sformatf("accuracy_%0d", i), 32'(err <= 1.0 / 131072.0), 32'd1);
        end

        // Release reset, then first loads
        @(negedge clock);
        reset_n = 1'b1;
        index   = 5'd3;
        @(posedge clock); #1;
        check("rel_q3", 32'(return_angle_q), 32'd8150);
        check("rel_last3", 32'(last_q), 32'd0);
        @(negedge clock);
        index = 5'd16;
        @(posedge clock); #1;
        check("rel_q16", 32'(return_angle_q), 32'd1);
        check("rel_last16", 32'(last_q), 32'd1);

        // Counter 0..16 then wrap: q lags comb by exactly one cycle
        @(negedge clock);
        index = 5'd0;
        for (int n = 0; n < 34; n++) begin
            #1;
            check($sformatf("cnt_comb_%0d", n), 32'(return_angle), 32'(ref_angle(int'(index))));
            prev_angle = return_angle;
            prev_idx   = index;
            @(posedge clock); #1;
            check($sformatf("cnt_q_%0d", n), 32'(return_angle_q), 32'(prev_angle));
            check($sformatf("cnt_last_%0d", n), 32'(last_q), 32'(prev_idx == 5'd16));
            @(negedge clock);
            index = (n < 16) ? index + 5'd1 : 5'(n + 15);
        end

        // Wrap 31 -> 0
        index = 5'd31;
        @(posedge clock); #1;
        check("wrap_q31", 32'(return_angle_q), 32'd0);
        @(negedge clock);
        index = 5'd0;
        @(posedge clock); #1;
        check("wrap_q0", 32'(return_angle_q), 32'd51472);
        check("wrap_last0", 32'(last_q), 32'd0);

        // Asynchronous reset between edges
        @(negedge clock);
        index = 5'd1;
        @(posedge clock); #1;
        check("async_pre_q", 32'(return_angle_q), 32'd30386);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_q", 32'(return_angle_q), 32'd0);
        check("async_last", 32'(last_q), 32'd0);
        check("async_comb", 32'(return_angle), 32'd30386);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("async_reload_q", 32'(return_angle_q), 32'd30386);

        // Randomized indices against the reference model
        for (int n = 0; n < 200; n++) begin
            @(negedge clock);
            cur   = 5'($urandom_range(0, 31));
            index = cur;
            #1;
            check("rand_comb", 32'(return_angle), 32'(ref_angle(int'(cur))));
            @(posedge clock); #1;
            check("rand_q", 32'(return_angle_q), 32'(ref_angle(int'(cur))));
            check("rand_last", 32'(last_q), 32'(cur == 5'd16));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
